// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: states, opcodes,
// ALU control codes, ALUSrcB selectors and instruction classes.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned CLS_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_WB_MEM = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_WB_ALU = 4'd8,
        S_BRANCH = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [CLS_W-1:0] CLS_MEM  = 3'd0;
    localparam logic [CLS_W-1:0] CLS_R    = 3'd1;
    localparam logic [CLS_W-1:0] CLS_I    = 3'd2;
    localparam logic [CLS_W-1:0] CLS_BR   = 3'd3;
    localparam logic [CLS_W-1:0] CLS_NONE = 3'd4;

    // Coarse instruction class from the opcode field.
    function automatic logic [CLS_W-1:0] op_class(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW: return CLS_MEM;
            OP_R:         return CLS_R;
            OP_I:         return CLS_I;
            OP_BR:        return CLS_BR;
            default:      return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational funct decoder: ALU operation and legality for each instruction class.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] cls,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (cls)
            CLS_MEM: illegal = (funct3 != 3'b010);
            CLS_BR: begin
                alu_ctrl = ALU_SUB;
                illegal  = (funct3 != 3'b000);
            end
            CLS_R: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0100000) alu_ctrl = ALU_SUB;
                        else if (funct7 != 7'b0000000) illegal = 1'b1;
                    end
                    3'b111: begin
                        alu_ctrl = ALU_AND;
                        illegal  = (funct7 != 7'b0000000);
                    end
                    3'b110: begin
                        alu_ctrl = ALU_OR;
                        illegal  = (funct7 != 7'b0000000);
                    end
                    default: illegal = 1'b1;
                endcase
            end
            CLS_I: begin
                case (funct3)
                    3'b000:  alu_ctrl = ALU_ADD;
                    3'b111:  alu_ctrl = ALU_AND;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RISC-V control FSM with retired-instruction counter.
// Define ILLEGAL_HALT_EN to trap illegal instructions in a sticky HALT state.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         inst,
    input  logic                zero,
    output logic                PCWrite,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic                PCSource,
    output logic [1:0]          ALUSrcB,
    output logic [3:0]          ALUControl,
    output logic [3:0]          state,
    output logic                instr_done,
    output logic [RETIRE_W-1:0] retired,
    output logic                halt
);

    state_t           state_r;
    logic [CLS_W-1:0] cls;
    logic [3:0]       funct_alu;
    logic             illegal;
    logic             unused_inst_bits;

    assign cls              = op_class(inst[6:0]);
    assign unused_inst_bits = ^{inst[24:15], inst[11:7]};
    assign state            = state_r;

    mc_alu_decoder u_alu_decoder (
        .cls      (cls),
        .funct3   (inst[14:12]),
        .funct7   (inst[31:25]),
        .alu_ctrl (funct_alu),
        .illegal  (illegal)
    );

    // State register, next-state selection and retired counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
            retired <= '0;
        end else begin
            if (instr_done) retired <= retired + RETIRE_W'(1);
            case (state_r)
                S_FETCH: state_r <= S_DECODE;
                S_DECODE: begin
                    if (illegal) begin
`ifdef ILLEGAL_HALT_EN
                        state_r <= S_HALT;
`else
                        state_r <= S_FETCH;
`endif
                    end else begin
                        case (cls)
                            CLS_MEM: state_r <= S_MEMADR;
                            CLS_R:   state_r <= S_EXEC_R;
                            CLS_I:   state_r <= S_EXEC_I;
                            default: state_r <= S_BRANCH;
                        endcase
                    end
                end
                S_MEMADR: state_r <= (inst[6:0] == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_r <= S_WB_MEM;
                S_EXEC_R: state_r <= S_WB_ALU;
                S_EXEC_I: state_r <= S_WB_ALU;
`ifdef ILLEGAL_HALT_EN
                S_HALT:   state_r <= S_HALT;
`endif
                default:  state_r <= S_FETCH;
            endcase
        end
    end

    // Datapath controls decoded from the state register; reset masks every enable.
    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        PCSource   = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_ADD;
        instr_done = 1'b0;
        case (state_r)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = SRCB_FOUR;
            end
            S_DECODE: begin
                PCWrite  = 1'b1;
                PCSource = 1'b1;
                ALUSrcB  = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_WB_MEM: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
            end
            S_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = funct_alu;
            end
            S_WB_ALU: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSource   = 1'b1;
                PCWrite    = zero;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite    = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

`ifdef ILLEGAL_HALT_EN
    assign halt = (state_r == S_HALT) && !reset;
`else
    assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed instructions plus random
// instruction streams checked against a per-instruction reference model.
module tb_mc_control_unit;

    localparam int unsigned RW = 4;

    logic          clk;
    logic          reset;
    logic [31:0]   inst;
    logic          zero;
    logic          PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, PCSource;
    logic [1:0]    ALUSrcB;
    logic [3:0]    ALUControl;
    logic [3:0]    state;
    logic          instr_done;
    logic [RW-1:0] retired;
    logic          halt;

    int nvec = 0;
    int nerr = 0;
    int model_cnt = 0;

    int         exp_seq[6];
    int         exp_len;
    bit         exp_legal;
    logic [3:0] exp_alu;

    mc_control_unit #(.RETIRE_W(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst       (inst),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .PCSource   (PCSource),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .state      (state),
        .instr_done (instr_done),
        .retired    (retired),
        .halt       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: legality, state walk and ALU op of one instruction.
    task automatic predict(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        exp_legal = 1'b0;
        exp_alu   = 4'b0010;
        exp_len   = 2;
        exp_seq[0] = 0;
        exp_seq[1] = 1;
        case (op)
            7'b0000011: if (f3 == 3'd2) begin
                exp_legal = 1'b1; exp_len = 5;
                exp_seq[2] = 2; exp_seq[3] = 3; exp_seq[4] = 4;
            end
            7'b0100011: if (f3 == 3'd2) begin
                exp_legal = 1'b1; exp_len = 4;
                exp_seq[2] = 2; exp_seq[3] = 5;
            end
            7'b0110011: begin
                if ({f7, f3} == {7'h00, 3'd0})      begin exp_legal = 1'b1; exp_alu = 4'b0010; end
                else if ({f7, f3} == {7'h20, 3'd0}) begin exp_legal = 1'b1; exp_alu = 4'b0110; end
                else if ({f7, f3} == {7'h00, 3'd7}) begin exp_legal = 1'b1; exp_alu = 4'b0000; end
                else if ({f7, f3} == {7'h00, 3'd6}) begin exp_legal = 1'b1; exp_alu = 4'b0001; end
                if (exp_legal) begin exp_len = 4; exp_seq[2] = 6; exp_seq[3] = 8; end
            end
            7'b0010011: begin
                if (f3 == 3'd0)      begin exp_legal = 1'b1; exp_alu = 4'b0010; end
                else if (f3 == 3'd7) begin exp_legal = 1'b1; exp_alu = 4'b0000; end
                else if (f3 == 3'd6) begin exp_legal = 1'b1; exp_alu = 4'b0001; end
                if (exp_legal) begin exp_len = 4; exp_seq[2] = 7; exp_seq[3] = 8; end
            end
            7'b1100011: if (f3 == 3'd0) begin
                exp_legal = 1'b1; exp_len = 3; exp_seq[2] = 9;
            end
            default: ;
        endcase
    endtask

    // Expected {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,PCSource,ALUSrcB,ALUControl,instr_done,halt}.
    function automatic logic [16:0] expvec(input int s, input bit last, input bit z);
        logic [1:0] srcb;
        logic [3:0] alu;
        srcb = (s == 0) ? 2'b01 : ((s == 1 || s == 2 || s == 7) ? 2'b10 : 2'b00);
        alu  = (s == 6 || s == 7) ? exp_alu : ((s == 9) ? 4'b0110 : 4'b0010);
        return {(s == 1) || (s == 9 && z), s == 3 || s == 5, s == 0 || s == 3, s == 5, s == 0,
                s == 4, s == 4 || s == 8, s == 2 || s == 6 || s == 7 || s == 9, s == 1 || s == 9,
                srcb, alu, last && exp_legal, 1'b0};
    endfunction

    function automatic logic [16:0] gotvec();
        return {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, PCSource,
                ALUSrcB, ALUControl, instr_done, halt};
    endfunction

    task automatic do_reset(input string name, input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            #1;
            nvec++;
            if ({PCWrite, MemRead, MemWrite, IRWrite, RegWrite, instr_done, halt} !== 7'b0) begin
                nerr++;
                $display("FAIL %s: enables in reset got %b want 0000000", name,
                         {PCWrite, MemRead, MemWrite, IRWrite, RegWrite, instr_done, halt});
            end
            @(negedge clk);
        end
        reset = 1'b0;
        model_cnt = 0;
        #1;
        nvec++;
        if ({state, retired, IRWrite, MemRead, ALUSrcB} !== {4'd0, RW'(0), 1'b1, 1'b1, 2'b01}) begin
            nerr++;
            $display("FAIL %s: after reset state=%0d retired=%0d IRWrite=%b MemRead=%b ALUSrcB=%b want 0 0 1 1 01",
                     name, state, retired, IRWrite, MemRead, ALUSrcB);
        end
    endtask

`ifdef ILLEGAL_HALT_EN
    task automatic check_halt(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            #1;
            nvec++;
            if ({state, halt, PCWrite, MemRead, MemWrite, IRWrite, RegWrite, instr_done} !== {4'd10, 1'b1, 6'b0}) begin
                nerr++;
                $display("FAIL %s: halt cyc%0d state=%0d halt=%b got enables %b want state 10 halt 1",
                         name, i, state, halt, {PCWrite, MemRead, MemWrite, IRWrite, RegWrite, instr_done});
            end
            @(negedge clk);
        end
        do_reset(name, 2);
    endtask
`endif

    // Runs one instruction from FETCH, checking state and controls every cycle.
    task automatic run_instr(input string name, input logic [31:0] ins, input bit z);
        logic [16:0] want;
        predict(ins);
        inst = ins;
        zero = z;
        for (int i = 0; i < exp_len; i++) begin
            #1;
            want = expvec(exp_seq[i], i == exp_len - 1, z);
            nvec++;
            if (state !== 4'(exp_seq[i])) begin
                nerr++;
                $display("FAIL %s cyc%0d: state got %0d want %0d", name, i, state, exp_seq[i]);
            end
            nvec++;
            if (gotvec() !== want) begin
                nerr++;
                $display("FAIL %s cyc%0d: controls got %h want %h", name, i, gotvec(), want);
            end
            @(negedge clk);
        end
        if (exp_legal) model_cnt++;
`ifdef ILLEGAL_HALT_EN
        if (!exp_legal) check_halt(name, 3);
`endif
        #1;
        nvec++;
        if ({state, retired} !== {4'd0, RW'(model_cnt)}) begin
            nerr++;
            $display("FAIL %s: end state=%0d retired=%0d want state 0 retired %0d",
                     name, state, retired, RW'(model_cnt));
        end
    endtask

    task automatic test_reset();
        do_reset("reset", 3);
    endtask

    task automatic test_alu_ops();
        run_instr("addi", 32'h0c800093, 1'b0);
        run_instr("sub", 32'h402082b3, 1'b1);
        run_instr("and", 32'h0020f1b3, 1'b0);
        run_instr("ori", 32'h0ff0e193, 1'b0);
    endtask

    task automatic test_mem();
        run_instr("lw", 32'hfce0a103, 1'b0);
        run_instr("sw", 32'hfe30a623, 1'b1);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", 32'h00000463, 1'b1);
        run_instr("beq_not", 32'h00000463, 1'b0);
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_HALT_EN
        predict(32'hffffffff);
        inst = 32'hffffffff;
        repeat (2) @(negedge clk);
        check_halt("illegal_halt", 20);
`else
        run_instr("illegal", 32'hffffffff, 1'b0);
        run_instr("bad_funct7_or", 32'h4020e1b3, 1'b0);
        run_instr("lw_bad_f3", 32'h0000b103, 1'b0);
`endif
    endtask

    task automatic test_reset_mid_lw();
        inst = 32'hfce0a103;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        nvec++;
        if ({state, RegWrite, MemWrite, MemRead} !== {4'd3, 3'b000}) begin
            nerr++;
            $display("FAIL reset_mid_lw: in reset state=%0d RegWrite=%b MemWrite=%b MemRead=%b want 3 0 0 0",
                     state, RegWrite, MemWrite, MemRead);
        end
        @(negedge clk);
        reset = 1'b0;
        model_cnt = 0;
        #1;
        nvec++;
        if ({state, retired, RegWrite} !== {4'd0, RW'(0), 1'b0}) begin
            nerr++;
            $display("FAIL reset_mid_lw: after state=%0d retired=%0d RegWrite=%b want 0 0 0",
                     state, retired, RegWrite);
        end
    endtask

    // Back-to-back random instructions; the small counter wraps several times.
    task automatic test_random(input int n);
        logic [6:0]  ops[5];
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] rnd;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
        for (int k = 0; k < n; k++) begin
            rnd = $urandom();
            if ($urandom_range(0, 9) == 0) op = rnd[6:0];
            else op = ops[$urandom_range(0, 4)];
            rnd = $urandom();
            f3 = rnd[14:12];
            f7 = rnd[31:25];
            if ($urandom_range(0, 3) != 0) begin
                if (op == 7'b0000011 || op == 7'b0100011) f3 = 3'd2;
                else if (op == 7'b1100011) f3 = 3'd0;
                else begin
                    case ($urandom_range(0, 2))
                        0: f3 = 3'd0;
                        1: f3 = 3'd7;
                        default: f3 = 3'd6;
                    endcase
                    if (op == 7'b0110011)
                        f7 = (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end
            end
            run_instr("random", {f7, rnd[24:15], f3, rnd[11:7], op}, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset = 1'b1;
        inst  = 32'h0;
        zero  = 1'b0;
        test_reset();
        test_alu_ops();
        test_mem();
        test_beq();
        test_illegal();
        test_reset_mid_lw();
        test_random(200);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
